// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Fixed-latency memory model answering a cache's line-sized requests.
//   A request is accepted in IDLE (or in the RESP cycle of the previous
//   request). One response appears LATENCY cycles later. Requests that arrive
//   while a response is still pending are dropped.
//   Storage is 2**LINE_AW lines of 128 bits. Reset does not clear it; its
//   power-up content gives word k of line L the value L*4+k.
//
// Optional feature macro: CACHE_MEM_STATS_EN
//   When defined, the rd_cnt/wr_cnt ports are added. They are saturating
//   counters of accepted reads and writes.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   mem_req   in   addr[31:0], data[127:0], rw (1=write), valid
//   mem_data  out  data[127:0], ready (one-cycle response strobe)
//   busy      out  high while a request is accepted and not yet answered
//   rd_cnt    out  accepted reads  (CACHE_MEM_STATS_EN only)
//   wr_cnt    out  accepted writes (CACHE_MEM_STATS_EN only)

package cache_mem_pkg;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

endpackage

module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINE_AW = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy
`ifdef CACHE_MEM_STATS_EN
  ,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt
`endif
);

  localparam int unsigned NLINES = 2 ** LINE_AW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t               state_q;
  logic [7:0]           cnt_q;
  logic                 rw_q;
  logic [LINE_AW-1:0]   idx_q;
  logic [127:0]         wdata_q;
  logic                 ready_q;
  logic [127:0]         rdata_q;
  logic                 busy_q;

  logic                 accept;
  logic                 wr_en;
  logic [LINE_AW-1:0]   acc_idx;
  logic [127:0]         store_rd [NLINES];
  logic                 unused_addr;

  // The byte offset and the address bits above the line index do not
  // select anything. Addresses that differ only in those bits alias.
  assign acc_idx     = mem_req.addr[LINE_AW+3:4];
  assign unused_addr = ^{mem_req.addr[31:LINE_AW+4], mem_req.addr[3:0]};

  // The RESP cycle may accept a new request. This lets a write-back be
  // followed by an allocate with no idle cycle in between.
  assign accept = mem_req.valid && (state_q != WAIT);
  assign wr_en  = accept && mem_req.rw;

  // Storage: one register per line, with a power-up value and no reset.
  // Writes land at the acceptance edge, so a read response for the same
  // line always sees the new data.
  for (genvar l = 0; l < NLINES; l++) begin : g_line
    logic [127:0] line_q = {32'(l * 4 + 3), 32'(l * 4 + 2), 32'(l * 4 + 1), 32'(l * 4)};

    always_ff @(posedge clk) begin
      if (wr_en && (acc_idx == LINE_AW'(l))) begin
        line_q <= mem_req.data;
      end
    end

    assign store_rd[l] = line_q;
  end

  // Control FSM. ready, data and busy are registered. The response data is
  // captured at the edge that enters RESP. No write can land between that
  // edge and the end of RESP, so this equals a read taken during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      rw_q    <= mem_req.rw;
      idx_q   <= acc_idx;
      wdata_q <= mem_req.data;
      busy_q  <= 1'b1;
      if (LATENCY == 1) begin
        state_q <= RESP;
        cnt_q   <= '0;
        ready_q <= 1'b1;
        rdata_q <= mem_req.rw ? mem_req.data : store_rd[acc_idx];
      end else begin
        state_q <= WAIT;
        cnt_q   <= 8'(LATENCY - 1);
        ready_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        WAIT: begin
          if (cnt_q == 8'd1) begin
            state_q <= RESP;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            rdata_q <= rw_q ? wdata_q : store_rd[idx_q];
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data.data  = rdata_q;
  assign mem_data.ready = ready_q;
  assign busy           = busy_q;

`ifdef CACHE_MEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept) begin
      if (mem_req.rw) begin
        if (wr_cnt_q != '1) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
      end else if (rd_cnt_q != '1) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 LATENCY, default 4, cycles from request acceptance to response; legal range 1..255.
REQ-002 LINE_AW, default 10, line-index width; storage holds 2**LINE_AW lines of 128 bits.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 mem_req  input  mem_req_type  request from the cache: addr[31:0], data[127:0], rw (1=write), valid.
REQ-006 mem_data  output  mem_data_type  response to the cache: data[127:0], ready.
REQ-007 busy  output  1  high while a request is accepted and not yet answered.

Function
REQ-008 FSM states: IDLE, WAIT, RESP.
REQ-009 IDLE: mem_req.valid=1 at a rising edge accepts the request and goes to WAIT, or to RESP when LATENCY=1.
REQ-010 Acceptance latches rw, line index = addr[LINE_AW+3:4], and write data; addr[3:0] and addr bits above LINE_AW+3 are ignored (aliasing permitted).
REQ-011 A write request updates the storage line at the acceptance edge.
REQ-012 WAIT: a down-counter loaded with LATENCY-1 at acceptance decrements each cycle; on reaching 1 the FSM enters RESP.
REQ-013 Request accepted at edge T -> mem_data.ready high for exactly the cycle following edge T+LATENCY-1.
REQ-014 RESP: ready=1 for one cycle; for reads, mem_data.data = stored line, read in that cycle after any write already applied; for writes, mem_data.data = written data.
REQ-015 RESP with mem_req.valid=1 in the same cycle accepts the new request (write-back followed by allocate with no idle cycle); otherwise RESP -> IDLE.
REQ-016 mem_req.valid in WAIT is ignored and never queued; the cache holds it only one cycle, so such a request is lost by design.
REQ-017 mem_data.data holds its last value when ready=0.
REQ-018 busy = 1 in WAIT and RESP, 0 in IDLE.
REQ-019 Storage initial content, not affected by reset: 32-bit word k (0..3) of line L = L*4+k.

Reset
REQ-020 rst_n=0 forces IDLE, counter 0, mem_data.ready=0, mem_data.data=0, busy=0, asynchronously.
REQ-021 Reset mid-request abandons the request with no response; a write already applied at acceptance remains in storage.
REQ-022 First acceptance possible at the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro CACHE_MEM_STATS_EN defined: adds outputs rd_cnt[15:0] and wr_cnt[15:0], incremented at each accepted read/write, saturating at 16'hFFFF, reset to 0.
REQ-024 Macro undefined: those ports and counters are absent; all other behaviour is identical.

Verification (LATENCY=4, LINE_AW=10)
REQ-025 Read addr 32'h0000_0010 valid one cycle at edge 0 -> ready high only after edge 3, data = {32'd7, 32'd6, 32'd5, 32'd4}, busy 1 for 4 cycles.
REQ-026 Write addr 32'h0000_0020, data all-A5 -> ready after edge 3; a later read of 32'h0000_4020 (alias) returns all-A5.
REQ-027 Write line 5, valid held high again in the RESP cycle as a read of line 9 -> read accepted with zero gap, second ready 4 cycles after the first, data = words 36..39.
REQ-028 Valid pulses in WAIT cycles -> no extra ready; exactly one response per accepted request.
REQ-029 rst_n low for one cycle during WAIT -> ready never asserted, data=0, IDLE; the next request is served normally.
REQ-030 CACHE_MEM_STATS_EN defined: 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2; with the counters forced to 16'hFFFF, a further read leaves rd_cnt at 16'hFFFF.
